// File: rtl/result_nibble_collector_pkg.sv
// Shared types and sizing helpers for the nibble result collector.
// Burst reassembly state and index-width derivation live here.
package result_nibble_collector_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    ASSEMBLE = 1'b1
  } state_t;

  function automatic int nibbles(input int n, input int w);
    return n / w;
  endfunction

  function automatic int idx_w(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/result_nibble_collector_if.sv
// Nibble stream in, result words out, grouped as one bundle.
// master drives nibbles and ready; slave is the collector.
interface result_nibble_collector_if #(
  parameter int N       = 64,
  parameter int N_width = 4
);
  logic               nib_valid;
  logic [N_width-1:0] nib_data;
  logic               word_ready;
  logic               word_valid;
  logic [N-1:0]       word_data;

  modport master (
    output nib_valid, nib_data, word_ready,
    input  word_valid, word_data
  );

  modport slave (
    input  nib_valid, nib_data, word_ready,
    output word_valid, word_data
  );
endinterface

// File: rtl/result_nibble_collector_fifo.sv
// Small word FIFO; a push at full is accepted only
// when a pop frees the head slot on the same cycle.
module result_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             accept_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty_o  = (cnt_q == '0);
  assign dout_o   = mem_q[rd_q];
  assign do_pop   = pop_i & ~empty_o;
  assign do_push  = push_i & (~full | do_pop);
  assign accept_o = do_push;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din_i;
      wr_d        = wr_q + PW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + PW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/result_nibble_collector.sv
// Reassembles nibble bursts into N-bit words, LSB nibble first,
// and queues them; flags short bursts and dropped words.
module result_nibble_collector
  import result_nibble_collector_pkg::*;
#(
  parameter int N       = 64,
  parameter int N_width = 4,
  parameter int DEPTH   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  result_nibble_collector_if.slave   bus,
  output logic                       busy,
  output logic                       frag_err,
  output logic                       overflow,
  output logic [7:0]                 word_count
);
  localparam int NIBBLES = nibbles(N, N_width);
  localparam int IDX_W   = idx_w(NIBBLES);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     asm_q, asm_d;
  logic             frag_q, frag_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             push;
  logic             pop;
  logic             accept;
  logic             empty;

  assign pop = bus.word_valid & bus.word_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    frag_d  = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.nib_valid) begin
          asm_d                 = '0;
          asm_d[0 +: N_width]   = bus.nib_data;
          if (NIBBLES == 1) begin
            push = 1'b1;
          end else begin
            idx_d   = IDX_W'(1);
            state_d = ASSEMBLE;
          end
        end
      end
      ASSEMBLE: begin
        if (bus.nib_valid) begin
          asm_d[int'(idx_q)*N_width +: N_width] = bus.nib_data;
          if (idx_q == IDX_W'(NIBBLES - 1)) begin
            push    = 1'b1;
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          // short burst: drop the partial word
          frag_d  = 1'b1;
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ovf_d = push & ~accept;
    cnt_d = cnt_q + 8'(accept);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      asm_q   <= '0;
      frag_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      frag_q  <= frag_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  result_fifo #(
    .WIDTH (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (push),
    .pop_i    (pop),
    .din_i    (asm_d),
    .dout_o   (bus.word_data),
    .empty_o  (empty),
    .accept_o (accept)
  );

  assign bus.word_valid = ~empty;
  assign busy           = (state_q == ASSEMBLE);
  assign frag_err       = frag_q;
  assign overflow       = ovf_q;
  assign word_count     = cnt_q;
endmodule
